// File: rtl/afifo_rd_drain.sv
// Read-side drain for an async FIFO: hides the FIFO's one-cycle registered read behind a
// 3-entry elastic buffer and a valid/ready output, and counts delivered words.
module afifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rdclk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  logic [1:0]           occ_q, occ_d;
  logic [1:0]           head_q, head_d;
  logic [1:0]           tail_q, tail_d;
  logic                 infl_q;
  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           pend;
  logic                 push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the word still in flight so a read never outruns the buffer.
  assign pend       = {1'b0, occ_q} + {2'b00, infl_q};
  assign fifo_rd_en = ~arst & enable & ~fifo_empty & (pend < 3'd3);

  assign push     = infl_q;
  assign m_valid  = (occ_q != 2'd0);
  assign pop      = m_valid & m_ready;
  assign rd_count = cnt_q;

  always_comb begin
    m_data = mem_q[2];
    case (head_q)
      2'd0:    m_data = mem_q[0];
      2'd1:    m_data = mem_q[1];
      default: m_data = mem_q[2];
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (pop) begin
      head_d = ptr_inc(head_q);
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
  end

  always_ff @(posedge rdclk or posedge arst) begin
    if (arst) begin
      occ_q  <= 2'd0;
      head_q <= 2'd0;
      tail_q <= 2'd0;
      infl_q <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      infl_q <= fifo_rd_en;
      cnt_q  <= cnt_d;
      for (int i = 0; i < 3; i++) begin
        if (push && (tail_q == 2'(i))) begin
          mem_q[i] <= fifo_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Randomized bench for afifo_rd_drain: a queue-based FIFO source plus an
// "issued words appear two cycles later, in order" reference model.
module tb_afifo_rd_drain;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          rdclk = 1'b0;
  logic          arst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] rd_count;

  afifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rdclk(rdclk), .arst(arst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count)
  );

  always #5 rdclk = ~rdclk;

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } ent_t;

  int         checks = 0;
  int         failures = 0;
  ent_t       exp_q[$];
  logic [7:0] src[$];
  int         cyc = 0;
  int         delivered = 0;
  int         rd_pulses = 0;
  int         first_rd = -1;
  int         first_vld = -1;
  logic       pend_valid = 1'b0;
  logic [7:0] pend_word = '0;
  bit         rand_empty = 0;
  bit         rand_ready = 0;
  bit         en_cfg = 0;
  bit         rdy_cfg = 0;
  bit         watch_first = 0;
  logic [7:0] got_first = '0;
  logic [7:0] expect_first = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    check_eq({tag, "_m_valid"}, 32'(m_valid), 0);
    check_eq({tag, "_m_data"}, 32'(m_data), 0);
    check_eq({tag, "_rd_count"}, 32'(rd_count), 0);
  endtask

  // One clock: inputs change 1 after the edge, the model samples 2 after the edge.
  task automatic cycle();
    bit         exp_rd, exp_vld;
    logic [7:0] w;
    @(posedge rdclk);
    cyc++;
    #1;
    fifo_rd_data = pend_valid ? pend_word : 8'($urandom);
    pend_valid   = 1'b0;
    enable       = en_cfg;
    m_ready      = rand_ready ? 1'($urandom_range(0, 1)) : rdy_cfg;
    fifo_empty   = (src.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
    #1;
    exp_rd  = enable && !fifo_empty && (exp_q.size() < 3);
    exp_vld = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
    check_eq("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check_eq("m_valid", 32'(m_valid), 32'(exp_vld));
    if (exp_vld) check_eq("m_data", 32'(m_data), 32'(exp_q[0].dat));
    check_eq("rd_count", 32'(rd_count), 32'(delivered % 16));
    if (fifo_rd_en) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (watch_first && m_valid && m_ready) begin
      got_first   = m_data;
      watch_first = 0;
    end
    if (exp_vld && m_ready) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (exp_rd) begin
      w = src.pop_front();
      exp_q.push_back('{w, cyc});
      pend_valid = 1'b1;
      pend_word  = w;
    end
  endtask

  // Reset raised mid-cycle: the strobe of the current cycle never reaches an edge, so the
  // source keeps that word; the word already in flight is lost along with the buffer.
  task automatic reset_pulse(input int hold);
    #1;
    arst = 1'b1;
    #1;
    check_zero("rst_async");
    if (pend_valid) src.push_front(pend_word);
    pend_valid = 1'b0;
    exp_q.delete();
    delivered = 0;
    repeat (hold) begin
      @(posedge rdclk);
      #1 fifo_rd_data = 8'($urandom);
      #1 check_zero("rst_hold");
    end
    enable     = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    #1 arst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge rdclk);
    #2 check_zero("reset");
    #1 arst = 1'b0;

    // Streaming 0x11..0x18 at full rate
    for (int i = 0; i < 8; i++) src.push_back(8'(8'h11 + i));
    en_cfg = 1; rdy_cfg = 1;
    repeat (14) cycle();
    check_eq("latency", 32'(first_vld - first_rd), 2);
    check_eq("stream_cnt", 32'(rd_count), 8);

    // Backpressure: three reads then stall, head held
    for (int i = 0; i < 5; i++) src.push_back(8'(8'h21 + i));
    rdy_cfg = 0;
    rd_pulses = 0;
    repeat (8) cycle();
    check_eq("bp_pulses", 32'(rd_pulses), 3);
    check_eq("bp_hold", 32'(m_data), 32'h21);
    rdy_cfg = 1;
    repeat (10) cycle();
    check_eq("bp_cnt", 32'(rd_count), 13);

    // Fill to occ=2/infl=1, reset, then deliver 17 words to wrap the 4-bit counter
    for (int i = 0; i < 30; i++) src.push_back(8'($urandom));
    en_cfg = 1; rdy_cfg = 0;
    repeat (4) cycle();
    reset_pulse(3);
    expect_first = src[0];
    watch_first  = 1;
    rdy_cfg = 1;
    repeat (19) cycle();
    en_cfg = 0; rdy_cfg = 0;
    cycle();
    check_eq("wrap_cnt", 32'(rd_count), 1);
    check_eq("first_after_rst", 32'(got_first), 32'(expect_first));

    // Random empty/ready with an enable drop while a word is in flight
    for (int i = 0; i < 120; i++) src.push_back(8'($urandom));
    rand_empty = 1; rand_ready = 1; en_cfg = 1;
    repeat (60) cycle();
    begin
      bit found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
        cycle();
        found = fifo_rd_en;
      end
      check_eq("inflight_found", 32'(found), 1);
    end
    en_cfg = 0;
    repeat (4) cycle();
    en_cfg = 1;
    repeat (200) cycle();

    // Reset while actively reading
    rand_empty = 0; rand_ready = 0; rdy_cfg = 1;
    for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
    repeat (2) cycle();
    reset_pulse(2);

    // Drain everything
    begin
      int k;
      for (k = 0; k < 400 && (src.size() > 0 || exp_q.size() > 0); k++) cycle();
      check_eq("drain_timeout", 32'(k < 400), 1);
    end
    repeat (3) cycle();
    check_eq("drain_valid", 32'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
